// File: rtl/imm_mov_encoder.sv
// rtl/imm_mov_encoder.sv - emits the shortest LEGv8 MOVZ/MOVK sequence for a 64-bit constant
module imm_mov_encoder (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic [63:0] Value,
    input  logic [4:0]  Rd,
    input  logic        InValid,
    output logic        InReady,
    output logic [31:0] Instr,
    output logic        OutValid,
    output logic        OutLast,
    input  logic        OutReady
);

    localparam logic [8:0] OPC_MOVZ = 9'b110100101;
    localparam logic [8:0] OPC_MOVK = 9'b111100101;

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_value;
    logic [4:0]  r_rd;
    logic [3:0]  r_mask;
    logic [31:0] r_instr;
    logic        r_out_valid;
    logic        r_out_last;

    logic [3:0]  w_in_mask;
    logic [3:0]  w_src_mask;
    logic [63:0] w_src_value;
    logic [4:0]  w_src_rd;
    logic        w_src_first;
    logic [1:0]  w_idx;
    logic [15:0] w_hw;
    logic        w_last;
    logic [31:0] w_word;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_in_mask[i] = (Value[16*i +: 16] != 16'h0);
        end
    end

    // The word to register next comes either from the incoming request or
    // from the latched mask with the just-accepted bit removed.
    always_comb begin
        w_src_mask  = w_in_mask;
        w_src_value = Value;
        w_src_rd    = Rd;
        w_src_first = 1'b1;
        if (r_state == S_EMIT) begin
            w_src_mask  = r_mask & (r_mask - 4'd1);
            w_src_value = r_value;
            w_src_rd    = r_rd;
            w_src_first = 1'b0;
        end

        casez (w_src_mask)
            4'b???1: w_idx = 2'd0;
            4'b??10: w_idx = 2'd1;
            4'b?100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase

        case (w_idx)
            2'd0:    w_hw = w_src_value[15:0];
            2'd1:    w_hw = w_src_value[31:16];
            2'd2:    w_hw = w_src_value[47:32];
            default: w_hw = w_src_value[63:48];
        endcase

        w_last = ((w_src_mask & (w_src_mask - 4'd1)) == 4'd0);
        w_word = {(w_src_first ? OPC_MOVZ : OPC_MOVK), w_idx, w_hw, w_src_rd};
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (InValid) w_state_nxt = S_EMIT;
            S_EMIT: if (OutReady && r_out_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            r_value     <= 64'h0;
            r_rd        <= 5'h0;
            r_mask      <= 4'h0;
            r_instr     <= 32'h0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (InValid) begin
                r_value     <= Value;
                r_rd        <= Rd;
                r_mask      <= w_in_mask;
                r_instr     <= w_word;
                r_out_valid <= 1'b1;
                r_out_last  <= w_last;
            end
        end else if (OutReady) begin
            if (r_out_last) begin
                r_mask      <= 4'h0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else begin
                r_mask      <= w_src_mask;
                r_instr     <= w_word;
                r_out_last  <= w_last;
            end
        end
    end

    assign InReady  = Reset_n && (r_state == S_IDLE);
    assign Instr    = r_instr;
    assign OutValid = r_out_valid;
    assign OutLast  = r_out_last;

endmodule

// File: tb/tb_imm_mov_encoder.sv
// tb/tb_imm_mov_encoder.sv - directed and randomized checks of imm_mov_encoder against a word-list model
module tb_imm_mov_encoder;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic [63:0] Value;
    logic [4:0]  Rd;
    logic        InValid;
    logic        InReady;
    logic [31:0] Instr;
    logic        OutValid;
    logic        OutLast;
    logic        OutReady;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    imm_mov_encoder dut (
        .CLK      (CLK),
        .Reset_n  (Reset_n),
        .Value    (Value),
        .Rd       (Rd),
        .InValid  (InValid),
        .InReady  (InReady),
        .Instr    (Instr),
        .OutValid (OutValid),
        .OutLast  (OutLast),
        .OutReady (OutReady)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: one word per nonzero halfword in ascending order, first is MOVZ.
    task automatic model(input logic [63:0] v, input logic [4:0] rd);
        logic [15:0] h;
        bit first;
        exp_q.delete();
        first = 1'b1;
        for (int i = 0; i < 4; i++) begin
            h = v[16*i +: 16];
            if (h != 0) begin
                exp_q.push_back((first ? 32'hD2800000 : 32'hF2800000) + (i << 21) + (32'(h) << 5) + 32'(rd));
                first = 1'b0;
            end
        end
        if (exp_q.size() == 0) exp_q.push_back(32'hD2800000 + 32'(rd));
    endtask

    task automatic run_seq(input logic [63:0] v, input logic [4:0] rd, input int first_stall,
                           input bit rand_stall, input int abort_after);
        int stalls;
        bit last;
        model(v, rd);
        chk("in_ready_idle", InReady, 1);
        Value   = v;
        Rd      = rd;
        InValid = 1'b1;
        @(negedge CLK);
        InValid = 1'b0;
        Value   = {$urandom, $urandom};
        Rd      = 5'($urandom);
        for (int k = 0; k < exp_q.size(); k++) begin
            last   = (k == exp_q.size() - 1);
            stalls = (k == 0) ? first_stall : (rand_stall ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s < stalls; s++) begin
                chk("stall_valid", OutValid, 1);
                chk("stall_instr", Instr, exp_q[k]);
                chk("stall_last", OutLast, last);
                chk("stall_in_ready", InReady, 0);
                OutReady = 1'b0;
                InValid  = 1'($urandom_range(0, 1));
                Value    = {$urandom, $urandom};
                @(negedge CLK);
            end
            chk("word_valid", OutValid, 1);
            chk("word_instr", Instr, exp_q[k]);
            chk("word_last", OutLast, last);
            OutReady = 1'b1;
            InValid  = 1'b0;
            @(negedge CLK);
            OutReady = 1'b0;
            if (k == abort_after) begin
                Reset_n = 1'b0;
                @(negedge CLK);
                chk("abort_valid", OutValid, 0);
                chk("abort_instr", Instr, 0);
                chk("abort_in_ready", InReady, 0);
                Reset_n = 1'b1;
                @(negedge CLK);
                chk("abort_in_ready_rel", InReady, 1);
                chk("abort_valid_rel", OutValid, 0);
                return;
            end
        end
        chk("done_valid", OutValid, 0);
        chk("done_in_ready", InReady, 1);
    endtask

    initial begin
        logic [63:0] v;
        Reset_n  = 1'b0;
        Value    = 64'h0;
        Rd       = 5'h0;
        InValid  = 1'b0;
        OutReady = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_valid", OutValid, 0);
        chk("rst_last", OutLast, 0);
        chk("rst_instr", Instr, 0);
        chk("rst_in_ready", InReady, 0);
        Reset_n = 1'b1;
        @(negedge CLK);
        chk("rel_in_ready", InReady, 1);

        model(64'h0, 5'd5);
        chk("model_zero", exp_q[0], 32'hD2800005);
        run_seq(64'h0, 5'd5, 0, 1'b0, -1);
        run_seq(64'h0000_0000_0000_1234, 5'd0, 0, 1'b0, -1);
        model(64'hDEAD_0000_0000_BEEF, 5'd3);
        chk("model_dead_n", exp_q.size(), 2);
        chk("model_dead_1", exp_q[1], 32'hF2FBD5A3);
        run_seq(64'hDEAD_0000_0000_BEEF, 5'd3, 0, 1'b0, -1);
        run_seq(64'hFFFF_0000_0000_0000, 5'd1, 0, 1'b0, -1);
        run_seq(64'h0001_0002_0003_0004, 5'd0, 3, 1'b0, -1);
        run_seq(64'h0001_0002_0003_0004, 5'd0, 0, 1'b0, 1);
        run_seq(64'h0000_0000_0000_1234, 5'd0, 0, 1'b0, -1);

        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 4; i++) begin
                v[16*i +: 16] = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
            end
            run_seq(v, 5'($urandom), int'($urandom_range(0, 2)), 1'b1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
